// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the round-robin comparator arbiter.
package cmp_arb_pkg;

  localparam int CMP_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, CMP, RESP} cmp_arb_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_flags_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or after ptr, wrapping mod NUM_REQ.
module rr_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_vld
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      idx = sum[ID_W-1:0];
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin shared magnitude comparator: IDLE grants and latches, CMP compares, RESP holds the tagged result.
// Optional signed compare selected per transaction when CMP_ARB_SIGNED_EN is defined.
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = CMP_DATA_W,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
`ifdef CMP_ARB_SIGNED_EN
  input  logic                      cmp_signed,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_gt,
  output logic                      resp_lt,
  output logic                      resp_eq,
  output logic                      busy
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  cmp_arb_state_t    state, state_next;
  logic [ID_W-1:0]   rr_ptr, grant_id, id_p0;
  logic [NUM_REQ-1:0] grant;
  logic              grant_vld, accept, resp_done, sgn_in, sgn_p0;
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [DATA_W-1:0] a_p0, b_p0;
  cmp_flags_t        flags_p1;

  // Sign-extend by one bit so a single signed compare covers both modes.
  function automatic cmp_flags_t compare(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic              sgn);
    logic signed [DATA_W:0] ea, eb;
    ea = {sgn & a[DATA_W-1], a};
    eb = {sgn & b[DATA_W-1], b};
    compare.gt = (ea > eb);
    compare.lt = (ea < eb);
    compare.eq = (ea == eb);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
    assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
  end

`ifdef CMP_ARB_SIGNED_EN
  assign sgn_in = cmp_signed;
`else
  assign sgn_in = 1'b0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  assign accept     = (state == IDLE) && grant_vld;
  assign resp_done  = (state == RESP) && resp_ready;
  // Gated by rst so the accept strobe drops the instant reset asserts.
  assign req_ready  = ((state == IDLE) && !rst) ? grant : '0;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_id    = id_p0;
  assign resp_gt    = flags_p1.gt;
  assign resp_lt    = flags_p1.lt;
  assign resp_eq    = flags_p1.eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_vld) state_next = CMP;
      CMP:     state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // p0: operands latched at acceptance; p1: registered compare flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      id_p0    <= '0;
      sgn_p0   <= 1'b0;
      flags_p1 <= '0;
    end else begin
      if (accept) begin
        a_p0   <= a_arr[grant_id];
        b_p0   <= b_arr[grant_id];
        id_p0  <= grant_id;
        sgn_p0 <= sgn_in;
        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
      if (state == CMP)   flags_p1 <= compare(a_p0, b_p0, sgn_p0);
      else if (resp_done) flags_p1 <= '0;
    end
  end

endmodule
